// File: rtl/key_event.sv
// Key press classifier: turns a debounced key level into SHORT / LONG / REPEAT events.
// Define KEY_EVENT_REPEAT_EN to enable auto-repeat events while a long press is held.
module key_event #(
  parameter logic [13:0] T1MS      = 14'd12000,
  parameter logic [9:0]  LONG_MS   = 10'd1000,
  parameter logic [9:0]  REPEAT_MS = 10'd200
) (
  input  logic       Sys_clk,
  input  logic       Sys_reset,
  input  logic       Key_level,
  input  logic       Evt_ack,
  input  logic       Ovf_clr,
  output logic       Evt_valid,
  output logic [1:0] Evt_code,
  output logic       Evt_ovf
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  localparam logic [1:0] CODE_SHORT  = 2'd1;
  localparam logic [1:0] CODE_LONG   = 2'd2;
  localparam logic [1:0] CODE_REPEAT = 2'd3;

  state_t      state, state_next;
  logic        prev_level, armed;
  logic        press_edge, release_edge;
  logic [13:0] presc;
  logic [9:0]  ms_cnt, ms_inc;
  logic        tick, long_due;
  logic        fire, ms_clear;
  logic [1:0]  fire_code;

  // A key already held when reset lifts must be seen released before it can press.
  assign press_edge   = Key_level & ~prev_level & armed;
  assign release_edge = ~Key_level & prev_level;
  assign tick         = (presc == T1MS - 14'd1);
  assign ms_inc       = (ms_cnt == 10'h3FF) ? ms_cnt : ms_cnt + 10'd1;
  assign long_due     = tick && (ms_inc == LONG_MS);

`ifdef KEY_EVENT_REPEAT_EN
  logic repeat_due;
  assign repeat_due = tick && (ms_inc == REPEAT_MS);
`else
  // REPEAT_MS only matters when auto-repeat is built in.
  if (REPEAT_MS != 10'd0) begin : g_repeat_unused
  end
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge Sys_clk or negedge Sys_reset) begin
    if (!Sys_reset) begin
      state      <= IDLE;
      prev_level <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state      <= state_next;
      prev_level <= Key_level;
      if (!Key_level) armed <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (press_edge) state_next = HELD;
      HELD:      if (release_edge) state_next = IDLE;
                 else if (long_due) state_next = LONG_HELD;
      LONG_HELD: if (release_edge) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    fire      = 1'b0;
    fire_code = 2'd0;
    ms_clear  = 1'b0;
    case (state)
      HELD: begin
        if (release_edge) begin
          fire      = 1'b1;
          fire_code = CODE_SHORT;
        end else if (long_due) begin
          fire      = 1'b1;
          fire_code = CODE_LONG;
          ms_clear  = 1'b1;
        end
      end
`ifdef KEY_EVENT_REPEAT_EN
      LONG_HELD: begin
        if (!release_edge && repeat_due) begin
          fire      = 1'b1;
          fire_code = CODE_REPEAT;
          ms_clear  = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Timebase runs only while the key is down; IDLE holds it at zero for the next press.
  always_ff @(posedge Sys_clk or negedge Sys_reset) begin
    if (!Sys_reset) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (state == HELD || state == LONG_HELD) begin
      presc <= tick ? 14'd0 : presc + 14'd1;
      if (ms_clear)  ms_cnt <= '0;
      else if (tick) ms_cnt <= ms_inc;
    end else begin
      presc  <= '0;
      ms_cnt <= '0;
    end
  end

  // Single-entry event holding register; an ack in the same cycle frees the slot.
  always_ff @(posedge Sys_clk or negedge Sys_reset) begin
    if (!Sys_reset) begin
      Evt_valid <= 1'b0;
      Evt_code  <= 2'd0;
      Evt_ovf   <= 1'b0;
    end else begin
      if (fire && (!Evt_valid || Evt_ack)) begin
        Evt_valid <= 1'b1;
        Evt_code  <= fire_code;
      end else if (Evt_valid && Evt_ack) begin
        Evt_valid <= 1'b0;
        Evt_code  <= 2'd0;
      end
      if (fire && Evt_valid && !Evt_ack) Evt_ovf <= 1'b1;
      else if (Ovf_clr)                  Evt_ovf <= 1'b0;
    end
  end

endmodule
